// File: rtl/bif_sync_pipe.sv
// Bus-interface synchroniser: a per-channel shift pipeline with exported taps, an optional
// 3-stage majority filter, edge pulses, a freeze hold and a stretched master reset.
`timescale 1ns/1ps
module bif_sync_pipe #(
  parameter int CHANNELS = 10,
  parameter int DEPTH    = 3,
  parameter int FILTER   = 0,
  parameter int MR_HOLD  = 4
) (
  input  logic                      OSC,
  input  logic                      CLEAR_n,
  input  logic [CHANNELS-1:0]       D_n,
  input  logic                      FREEZE,
  output logic [CHANNELS*DEPTH-1:0] TAP_n,
  output logic [CHANNELS-1:0]       FILT_n,
  output logic [CHANNELS-1:0]       ASSERT_P,
  output logic [CHANNELS-1:0]       DEASSERT_P,
  output logic                      MR_n
);

  localparam int TW = CHANNELS * DEPTH;
  localparam int CW = (MR_HOLD < 1) ? 1 : $clog2(MR_HOLD + 1);
  localparam logic [CW-1:0] MR_HOLD_C = CW'(MR_HOLD);

  generate
    if (CHANNELS < 1 || DEPTH < 1 || (FILTER == 1 && DEPTH < 3)) begin : g_bad_params
      $error("bif_sync_pipe: illegal CHANNELS/DEPTH/FILTER combination");
    end
  endgenerate

  logic [TW-1:0]       tap_q, tap_d;
  logic [CHANNELS-1:0] filt_q, filt_d;
  logic [CHANNELS-1:0] hist_q, hist_d;
  logic [CHANNELS-1:0] filt_src;
  logic [CW-1:0]       mr_cnt_q, mr_cnt_d;
  logic                mr_n_q, mr_n_d;

  // Stage k of every channel lives in one CHANNELS-wide slice, matching the TAP_n layout.
  generate
    if (FILTER == 1 && DEPTH >= 3) begin : g_maj
      logic [CHANNELS-1:0] s_a, s_b, s_c;
      assign s_a      = tap_q[(DEPTH-1)*CHANNELS +: CHANNELS];
      assign s_b      = tap_q[(DEPTH-2)*CHANNELS +: CHANNELS];
      assign s_c      = tap_q[(DEPTH-3)*CHANNELS +: CHANNELS];
      assign filt_src = (s_a & s_b) | (s_a & s_c) | (s_b & s_c);
    end else begin : g_last
      assign filt_src = tap_q[(DEPTH-1)*CHANNELS +: CHANNELS];
    end
  endgenerate

  always_comb begin
    tap_d  = tap_q;
    filt_d = filt_q;
    hist_d = hist_q;
    if (!FREEZE) begin
      tap_d[CHANNELS-1:0] = D_n;
      for (int k = 1; k < DEPTH; k++) begin
        tap_d[k*CHANNELS +: CHANNELS] = tap_q[(k-1)*CHANNELS +: CHANNELS];
      end
      filt_d = filt_src;
      hist_d = filt_q;
    end
  end

  // MR stretch runs independently of FREEZE and saturates at the hold count.
  always_comb begin
    mr_cnt_d = (mr_cnt_q == MR_HOLD_C) ? mr_cnt_q : mr_cnt_q + CW'(1);
    mr_n_d   = (mr_cnt_d == MR_HOLD_C);
  end

  always_ff @(posedge OSC or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      tap_q    <= '1;
      filt_q   <= '1;
      hist_q   <= '1;
      mr_cnt_q <= '0;
      mr_n_q   <= 1'b0;
    end else begin
      tap_q    <= tap_d;
      filt_q   <= filt_d;
      hist_q   <= hist_d;
      mr_cnt_q <= mr_cnt_d;
      mr_n_q   <= mr_n_d;
    end
  end

  // Held history keeps a pending edge alive through FREEZE; it pulses once on release.
  assign TAP_n      = tap_q;
  assign FILT_n     = filt_q;
  assign ASSERT_P   = hist_q & ~filt_q & ~{CHANNELS{FREEZE}};
  assign DEASSERT_P = ~hist_q & filt_q & ~{CHANNELS{FREEZE}};
  assign MR_n       = mr_n_q;

endmodule
